ahb3lite_sram_slave: RTL and testbench

//  AHB3-Lite responder: single-port word memory on a slave port of the AHB3-Lite interconnect.

---
 rtl/ahb3lite_sram_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_ahb3lite_sram_slave.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb3lite_sram_slave
// Purpose  : AHB3-Lite responder wrapping a single-port word memory. Decodes
//            address/data phases, inserts a fixed number of wait states per
//            OKAY data phase and produces the two-cycle ERROR response for
//            out-of-range, oversize or misaligned transfers.
// Ports    : HCLK       - clock, all state on the rising edge
//            HRESET     - synchronous active-high reset
//            HSEL       - slave select from the interconnect decoder
//            HADDR      - byte address (address phase)
//            HWDATA     - write data (data phase)
//            HRDATA     - read data, non-zero only in a read completion cycle
//            HWRITE     - 1 = write, 0 = read
//            HSIZE      - transfer size (0 byte .. 3 dword)
//            HBURST     - burst type, no effect
//            HPROT      - protection, no effect
//            HTRANS     - 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//            HMASTLOCK  - no effect
//            HREADY     - bus ready (muxed HREADYOUT)
//            HREADYOUT  - this slave's ready
//            HRESP      - 0 OKAY, 1 ERROR
// Revision : 1.0 - initial release
// ============================================================================
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BYTES  = HDATA_SIZE / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // One bit wider than HADDR so the byte range itself is representable.
  localparam logic [HADDR_SIZE:0] ADDR_LIMIT = (HADDR_SIZE + 1)'(MEM_DEPTH * BYTES);
  localparam logic [2:0]          MAX_SIZE   = 3'(LANE_W);
  localparam logic [3:0]          WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t state, state_next;
  logic [3:0] wait_cnt, wait_cnt_next;

  // Latched address-phase information for the transfer in its data phase.
  logic              dp_valid;
  logic              dp_write;
  logic [IDX_W-1:0]  dp_idx;
  logic [LANE_W-1:0] dp_lane;
  logic [2:0]        dp_size;

  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  logic              take;
  logic              out_of_range;
  logic              bad_size;
  logic              misaligned;
  logic              req_err;
  logic              good_accept;
  logic              bad_accept;
  logic              complete;
  logic              wr_commit;
  logic              rd_issue;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [BYTES-1:0]  wr_be;
  logic [HDATA_SIZE-1:0] rd_word;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // --------------------------------------------------------------------------
  // Address-phase decode
  // --------------------------------------------------------------------------
  // Only IDLE and ERR2 drive HREADYOUT high, so only they can see an accept.
  assign take = HSEL & HREADY & HTRANS[1] & ((state == ST_IDLE) | (state == ST_ERR2));

  assign out_of_range = {1'b0, HADDR} >= ADDR_LIMIT;
  assign bad_size     = HSIZE > MAX_SIZE;

  always_comb begin
    misaligned = 1'b0;
    case (HSIZE)
      3'd1:    misaligned = HADDR[0];
      3'd2:    misaligned = |HADDR[1:0];
      3'd3:    misaligned = |HADDR[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign req_err     = out_of_range | bad_size | misaligned;
  assign good_accept = take & ~req_err;
  assign bad_accept  = take & req_err;
  assign req_idx     = HADDR[LANE_W +: IDX_W];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    HREADYOUT     = 1'b1;
    HRESP         = 1'b0;
    case (state)
      ST_IDLE, ST_ERR2: begin
        HRESP      = (state == ST_ERR2);
        state_next = ST_IDLE;
        if (bad_accept) begin
          state_next = ST_ERR1;
        end else if (good_accept && (WAIT_STATES > 0)) begin
          state_next    = ST_WAIT;
          wait_cnt_next = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt == 4'd0) begin
          state_next = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = ST_ERR2;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Data-phase tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_lane  <= '0;
      dp_size  <= 3'd0;
    end else if (take) begin
      dp_valid <= ~req_err;
      dp_write <= HWRITE;
      dp_idx   <= req_idx;
      dp_lane  <= HADDR[LANE_W-1:0];
      dp_size  <= HSIZE;
    end else if (complete) begin
      dp_valid <= 1'b0;
    end
  end

  // An OKAY data phase completes in the first IDLE cycle after its accept.
  assign complete  = (state == ST_IDLE) & dp_valid;
  assign wr_commit = complete & dp_write;

  // 2^size contiguous byte lanes starting at the latched lane offset.
  assign wr_be = BYTES'(((32'd1 << (32'd1 << dp_size)) - 32'd1) << dp_lane);

  // The read register is loaded at the edge that starts the completion cycle:
  // the accept edge with no wait states, otherwise the last WAIT edge.
  assign rd_issue = (good_accept & ~HWRITE & (WAIT_STATES == 0)) |
                    ((state == ST_WAIT) & (wait_cnt == 4'd0) & ~dp_write);
  assign rd_idx   = (state == ST_WAIT) ? dp_idx : req_idx;

  // Write-first forwarding: a write committing on the same edge to the same
  // word overrides its enabled bytes in the returned data.
  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < BYTES; i++) begin
      if (wr_commit && wr_be[i] && (dp_idx == rd_idx)) begin
        rd_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && wr_commit) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_be[i]) begin
          mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HRDATA <= '0;
    end else if (rd_issue) begin
      HRDATA <= rd_word;
    end else begin
      HRDATA <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb3lite_sram_slave
// Purpose  : Directed self-checking bench. Two instances share the bus
//            signals: u_dut0 with no wait states, u_dut3 with three. Each
//            instance's HREADY is its own HREADYOUT (single-slave bus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb3lite_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel0, sel3;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] rdata0, rdata3;
  wire         ro0, ro3;
  logic        resp0, resp3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ahb3lite_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0),
    .HPROT(4'd0), .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(ro0),
    .HREADYOUT(ro0), .HRESP(resp0)
  );

  ahb3lite_sram_slave #(.WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(rdata3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0),
    .HPROT(4'd0), .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(ro3),
    .HREADYOUT(ro3), .HRESP(resp3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    sel0   = 1'b0;
    sel3   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic addr_ph(input bit to3, input bit wr, input logic [31:0] a, input logic [2:0] sz);
    sel0   = !to3;
    sel3   = to3;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  // Single transfer: address phase, data phase until HREADYOUT, completion edge.
  task automatic xfer(input bit to3, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int lows,
                      output logic err);
    addr_ph(to3, wr, a, sz);
    tick();
    bus_idle();
    hwdata = wd;
    lows   = 0;
    while (((to3 ? ro3 : ro0) == 1'b0) && (lows < 20)) begin
      tick();
      lows++;
    end
    chk("xfer_ready", to3 ? ro3 : ro0, 1);
    rd  = to3 ? rdata3 : rdata0;
    err = to3 ? resp3 : resp0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lows;
    logic        err;

    rst = 1'b1; bus_idle(); hwrite = 1'b0; haddr = '0; hsize = '0; hwdata = '0;
    tick(); tick();
    chk("rst_ready0", ro0, 1);   chk("rst_resp0", resp0, 0);   chk("rst_rdata0", rdata0, 0);
    chk("rst_ready3", ro3, 1);   chk("rst_resp3", resp3, 0);   chk("rst_rdata3", rdata3, 0);
    rst = 1'b0;
    tick();

    // Word write then back-to-back read of the same word.
    addr_ph(0, 1, 32'h10, 3'd2); tick();
    chk("b2b_wr_ready", ro0, 1); chk("b2b_wr_rdata", rdata0, 0);
    addr_ph(0, 0, 32'h10, 3'd2); hwdata = 32'hDEADBEEF; tick();
    bus_idle();
    chk("b2b_rd_data", rdata0, 32'hDEADBEEF); chk("b2b_rd_ready", ro0, 1); chk("b2b_rd_resp", resp0, 0);
    tick();
    chk("rdata_idle_zero", rdata0, 0);

    // Byte write over a word, read merged back-to-back, then read from memory.
    addr_ph(0, 1, 32'h10, 3'd2); tick();
    addr_ph(0, 1, 32'h13, 3'd0); hwdata = 32'h11223344; tick();
    addr_ph(0, 0, 32'h10, 3'd2); hwdata = 32'hAA556677; tick();
    bus_idle();
    chk("raw_byte_merge", rdata0, 32'hAA223344);
    tick();
    xfer(0, 0, 32'h10, 3'd2, 32'h0, rd, lows, err);
    chk("byte_mem", rd, 32'hAA223344); chk("ws0_lows", lows, 0);

    // Halfword into upper lanes.
    xfer(0, 1, 32'h14, 3'd2, 32'h55667788, rd, lows, err);
    xfer(0, 1, 32'h16, 3'd1, 32'hBEEF1234, rd, lows, err);
    xfer(0, 0, 32'h14, 3'd2, 32'h0, rd, lows, err);
    chk("half_upper", rd, 32'hBEEF7788);

    // Last valid word.
    xfer(0, 1, 32'h3FC, 3'd2, 32'h0BADF00D, rd, lows, err);
    xfer(0, 0, 32'h3FC, 3'd2, 32'h0, rd, lows, err);
    chk("last_word", rd, 32'h0BADF00D); chk("last_word_resp", err, 0);

    // Three wait states.
    xfer(1, 1, 32'h20, 3'd2, 32'hCAFEF00D, rd, lows, err);
    chk("ws3_wr_lows", lows, 3);
    addr_ph(1, 0, 32'h20, 3'd2); tick(); bus_idle();
    for (int i = 0; i < 3; i++) begin
      chk("ws3_rd_wait", ro3, 0); chk("ws3_rd_zero", rdata3, 0);
      tick();
    end
    chk("ws3_rd_ready", ro3, 1); chk("ws3_rd_data", rdata3, 32'hCAFEF00D); chk("ws3_rd_resp", resp3, 0);
    tick();
    chk("ws3_after", rdata3, 0);

    // Error responses.
    xfer(0, 1, 32'h0, 3'd2, 32'h01020304, rd, lows, err);
    addr_ph(0, 0, 32'h400, 3'd2); tick(); bus_idle();
    chk("oor_err1_ready", ro0, 0); chk("oor_err1_resp", resp0, 1); chk("oor_err1_rdata", rdata0, 0);
    tick();
    chk("oor_err2_ready", ro0, 1); chk("oor_err2_resp", resp0, 1); chk("oor_err2_rdata", rdata0, 0);
    addr_ph(0, 0, 32'h10, 3'd2); tick(); bus_idle();
    chk("err2_acc_ready", ro0, 1); chk("err2_acc_resp", resp0, 0); chk("err2_acc_data", rdata0, 32'hAA223344);
    tick();

    addr_ph(0, 1, 32'h01, 3'd1); tick(); bus_idle(); hwdata = 32'hFFFFFFFF;
    chk("mis_err1_ready", ro0, 0); chk("mis_err1_resp", resp0, 1);
    tick();
    chk("mis_err2_ready", ro0, 1); chk("mis_err2_resp", resp0, 1);
    tick();
    chk("err_exit_resp", resp0, 0); chk("err_exit_ready", ro0, 1);

    xfer(0, 1, 32'h400, 3'd2, 32'hFFFFFFFF, rd, lows, err);
    chk("oor_wr_err", err, 1); chk("oor_wr_lows", lows, 1);
    xfer(0, 1, 32'h0, 3'd3, 32'hFFFFFFFF, rd, lows, err);
    chk("oversize_err", err, 1);
    xfer(0, 0, 32'h0, 3'd2, 32'h0, rd, lows, err);
    chk("mem_unchanged", rd, 32'h01020304); chk("mem_unchanged_resp", err, 0);

    // Reset during a waited write discards it.
    addr_ph(1, 1, 32'h20, 3'd2); tick(); bus_idle(); hwdata = 32'h12345678;
    chk("mid_wait", ro3, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_ready", ro3, 1); chk("rst_mid_resp", resp3, 0);
    rst = 1'b0;
    tick();
    xfer(1, 0, 32'h20, 3'd2, 32'h0, rd, lows, err);
    chk("rst_wr_discarded", rd, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
